// File: rtl/riscv_axi_pkg.sv
// Shared AXI constants and error-FSM state types for the DRAM window bridge.
// Window base/size default here unless RISCV_DRAM_BASE / RISCV_DRAM_BITS come from the build.
`ifndef RISCV_DRAM_BASE
`define RISCV_DRAM_BASE 32'h1000_0000
`endif
`ifndef RISCV_DRAM_BITS
`define RISCV_DRAM_BITS 28
`endif

package riscv_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] M_CACHE     = 4'b0011;
  localparam logic [2:0] M_PROT      = 3'b000;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, B_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_ERR}           rd_state_t;
endpackage

// File: rtl/riscv_dram_window_if.sv
// AXI4 bundle used on both sides of the DRAM window bridge.
// Attribute fields (lock/cache/prot/qos/region) are only carried by the master modport.
interface riscv_dram_window_if #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic                    awlock;
  logic [3:0]              awcache, awqos, awregion;
  logic [2:0]              awprot;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic                    arlock;
  logic [3:0]              arcache, arqos, arregion;
  logic [2:0]              arprot;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
           awlock, awcache, awprot, awqos, awregion,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
           arlock, arcache, arprot, arqos, arregion,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/riscv_dram_err_slave.sv
// Local DECERR responder: write FSM (drain W, answer B) and read FSM (emit len+1 error beats).
module riscv_dram_err_slave
  import riscv_axi_pkg::*;
#(
  parameter int ID_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_err_valid,
  input  logic [ID_WIDTH-1:0] aw_id,
  input  logic                wr_quiet,
  output logic                aw_err_ready,
  input  logic                w_valid,
  input  logic                w_last,
  output logic                w_drain,
  input  logic                b_ready,
  output logic                b_err_valid,
  output logic [ID_WIDTH-1:0] b_err_id,
  input  logic                ar_err_valid,
  input  logic [ID_WIDTH-1:0] ar_id,
  input  logic [7:0]          ar_len,
  input  logic                rd_quiet,
  output logic                ar_err_ready,
  input  logic                r_ready,
  output logic                r_err_valid,
  output logic [ID_WIDTH-1:0] r_err_id,
  output logic                r_err_last,
  output logic                wr_idle,
  output logic                rd_idle
);
  wr_state_t           wr_state_q, wr_state_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d, rid_q, rid_d;
  logic [7:0]          len_q, len_d, beat_q, beat_d;

  assign wr_idle      = (wr_state_q == W_IDLE);
  assign rd_idle      = (rd_state_q == R_IDLE);
  assign aw_err_ready = wr_idle && wr_quiet;
  assign ar_err_ready = rd_idle && rd_quiet;
  assign w_drain      = (wr_state_q == W_DRAIN);
  assign b_err_valid  = (wr_state_q == B_RESP);
  assign b_err_id     = wid_q;
  assign r_err_valid  = (rd_state_q == R_ERR);
  assign r_err_id     = rid_q;
  assign r_err_last   = (beat_q == len_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    unique case (wr_state_q)
      W_IDLE:  if (aw_err_valid && aw_err_ready) begin
                 wr_state_d = W_DRAIN;
                 wid_d      = aw_id;
               end
      W_DRAIN: if (w_valid && w_last) wr_state_d = B_RESP;
      B_RESP:  if (b_ready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Beat counter only moves on accepted beats so the master can throttle rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    len_d      = len_q;
    beat_d     = beat_q;
    unique case (rd_state_q)
      R_IDLE: if (ar_err_valid && ar_err_ready) begin
                rd_state_d = R_ERR;
                rid_d      = ar_id;
                len_d      = ar_len;
                beat_d     = '0;
              end
      R_ERR:  if (r_ready) begin
                if (beat_q == len_q) rd_state_d = R_IDLE;
                else                 beat_d     = beat_q + 8'd1;
              end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wid_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
    end
  end
endmodule

// File: rtl/riscv_dram_window.sv
// AXI4 bridge from core m0 to the Zynq HP/DRAM port: relocates the window, bounds in-flight bursts,
// answers out-of-window bursts locally with DECERR. Optional error log: RISCV_DRAM_WINDOW_ERRLOG_EN.
module riscv_dram_window
  import riscv_axi_pkg::*;
#(
  parameter int                    ID_WIDTH        = 5,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] DRAM_BASE       = `RISCV_DRAM_BASE,
  parameter int                    DRAM_BITS       = `RISCV_DRAM_BITS,
  parameter int                    MAX_OUTSTANDING = 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_write,
  input  logic                  err_clear,
`endif
  riscv_dram_window_if.slave    s_axi,
  riscv_dram_window_if.master   m_axi
);
  localparam int                    XW       = ADDR_WIDTH + 9;
  localparam logic [3:0]            MAX_C    = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ADDR_WIDTH'(1) << DRAM_BITS) - ADDR_WIDTH'(1);

  // Last byte is computed 9 bits wider than the address so a burst past the top cannot wrap.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size);
    logic [XW-1:0] last;
    last = {9'd0, addr} + (XW'({1'b0, len} + 9'd1) << size) - XW'(1);
    return ((addr >> DRAM_BITS) == '0) && ((last >> DRAM_BITS) == '0);
  endfunction

  logic       run;
  logic [3:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, w_owed_q, w_owed_d;
  logic       aw_win, ar_win, wr_room, rd_room;
  logic       aw_err_valid, aw_err_ready, ar_err_valid, ar_err_ready;
  logic       w_drain, b_err_valid, r_err_valid, r_err_last, wr_idle, rd_idle;
  logic [ID_WIDTH-1:0] b_err_id, r_err_id;
  logic       wr_inc, wr_dec, rd_inc, rd_dec, ow_dec;

  assign run     = !axi_areset;
  assign aw_win  = in_window(s_axi.awaddr, s_axi.awlen, s_axi.awsize);
  assign ar_win  = in_window(s_axi.araddr, s_axi.arlen, s_axi.arsize);
  assign wr_room = (wr_cnt_q < MAX_C) && wr_idle;
  assign rd_room = (rd_cnt_q < MAX_C) && rd_idle;

  // Write address
  assign aw_err_valid    = run && s_axi.awvalid && !aw_win;
  assign m_axi.awvalid   = run && s_axi.awvalid && aw_win && wr_room;
  assign s_axi.awready   = run && (aw_win ? (wr_room && m_axi.awready) : aw_err_ready);
  assign m_axi.awid      = s_axi.awid;
  assign m_axi.awaddr    = DRAM_BASE | (s_axi.awaddr & OFF_MASK);
  assign m_axi.awlen     = s_axi.awlen;
  assign m_axi.awsize    = s_axi.awsize;
  assign m_axi.awburst   = s_axi.awburst;
  assign m_axi.awlock    = 1'b0;
  assign m_axi.awcache   = M_CACHE;
  assign m_axi.awprot    = M_PROT;
  assign m_axi.awqos     = 4'd0;
  assign m_axi.awregion  = 4'd0;

  // Write data flows only against an already-forwarded AW.
  assign m_axi.wvalid = run && s_axi.wvalid && (w_owed_q != '0);
  assign s_axi.wready = run && (w_drain || ((w_owed_q != '0) && m_axi.wready));
  assign m_axi.wdata  = s_axi.wdata;
  assign m_axi.wstrb  = s_axi.wstrb;
  assign m_axi.wlast  = s_axi.wlast;

  // Write response
  assign s_axi.bvalid = run && (b_err_valid || m_axi.bvalid);
  assign s_axi.bid    = b_err_valid ? b_err_id : m_axi.bid;
  assign s_axi.bresp  = b_err_valid ? RESP_DECERR : m_axi.bresp;
  assign m_axi.bready = run && !b_err_valid && s_axi.bready;

  // Read address
  assign ar_err_valid    = run && s_axi.arvalid && !ar_win;
  assign m_axi.arvalid   = run && s_axi.arvalid && ar_win && rd_room;
  assign s_axi.arready   = run && (ar_win ? (rd_room && m_axi.arready) : ar_err_ready);
  assign m_axi.arid      = s_axi.arid;
  assign m_axi.araddr    = DRAM_BASE | (s_axi.araddr & OFF_MASK);
  assign m_axi.arlen     = s_axi.arlen;
  assign m_axi.arsize    = s_axi.arsize;
  assign m_axi.arburst   = s_axi.arburst;
  assign m_axi.arlock    = 1'b0;
  assign m_axi.arcache   = M_CACHE;
  assign m_axi.arprot    = M_PROT;
  assign m_axi.arqos     = 4'd0;
  assign m_axi.arregion  = 4'd0;

  // Read data
  assign s_axi.rvalid = run && (r_err_valid || m_axi.rvalid);
  assign s_axi.rid    = r_err_valid ? r_err_id : m_axi.rid;
  assign s_axi.rdata  = r_err_valid ? '0 : m_axi.rdata;
  assign s_axi.rresp  = r_err_valid ? RESP_DECERR : m_axi.rresp;
  assign s_axi.rlast  = r_err_valid ? r_err_last : m_axi.rlast;
  assign m_axi.rready = run && !r_err_valid && s_axi.rready;

  assign wr_inc = m_axi.awvalid && m_axi.awready;
  assign wr_dec = m_axi.bvalid && m_axi.bready;
  assign rd_inc = m_axi.arvalid && m_axi.arready;
  assign rd_dec = m_axi.rvalid && m_axi.rready && m_axi.rlast;
  assign ow_dec = m_axi.wvalid && m_axi.wready && m_axi.wlast;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    w_owed_d = w_owed_q;
    if (wr_inc && !wr_dec) wr_cnt_d = wr_cnt_q + 4'd1;
    if (!wr_inc && wr_dec) wr_cnt_d = wr_cnt_q - 4'd1;
    if (rd_inc && !rd_dec) rd_cnt_d = rd_cnt_q + 4'd1;
    if (!rd_inc && rd_dec) rd_cnt_d = rd_cnt_q - 4'd1;
    if (wr_inc && !ow_dec) w_owed_d = w_owed_q + 4'd1;
    if (!wr_inc && ow_dec) w_owed_d = w_owed_q - 4'd1;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_owed_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      w_owed_q <= w_owed_d;
    end
  end

  // Error bursts wait for an empty direction: keeps same-ID order and stops R interleave.
  riscv_dram_err_slave #(.ID_WIDTH(ID_WIDTH)) u_err (
    .clk          (axi_aclk),
    .rst          (axi_areset),
    .aw_err_valid (aw_err_valid),
    .aw_id        (s_axi.awid),
    .wr_quiet     ((wr_cnt_q == '0) && (w_owed_q == '0)),
    .aw_err_ready (aw_err_ready),
    .w_valid      (run && s_axi.wvalid),
    .w_last       (s_axi.wlast),
    .w_drain      (w_drain),
    .b_ready      (run && s_axi.bready),
    .b_err_valid  (b_err_valid),
    .b_err_id     (b_err_id),
    .ar_err_valid (ar_err_valid),
    .ar_id        (s_axi.arid),
    .ar_len       (s_axi.arlen),
    .rd_quiet     (rd_cnt_q == '0),
    .ar_err_ready (ar_err_ready),
    .r_ready      (run && s_axi.rready),
    .r_err_valid  (r_err_valid),
    .r_err_id     (r_err_id),
    .r_err_last   (r_err_last),
    .wr_idle      (wr_idle),
    .rd_idle      (rd_idle)
  );

`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
  logic                  err_valid_q, err_valid_d, err_is_write_q, err_is_write_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // Sticky first-offender log; a write wins a same-cycle tie with a read.
  always_comb begin
    err_valid_d    = err_valid_q;
    err_addr_d     = err_addr_q;
    err_is_write_d = err_is_write_q;
    if (err_clear) begin
      err_valid_d = 1'b0;
    end else if (!err_valid_q && aw_err_valid && aw_err_ready) begin
      err_valid_d    = 1'b1;
      err_addr_d     = s_axi.awaddr;
      err_is_write_d = 1'b1;
    end else if (!err_valid_q && ar_err_valid && ar_err_ready) begin
      err_valid_d    = 1'b1;
      err_addr_d     = s_axi.araddr;
      err_is_write_d = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      err_valid_q    <= 1'b0;
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_is_write_q <= err_is_write_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_addr     = err_addr_q;
  assign err_is_write = err_is_write_q;
`endif
endmodule

// File: tb/tb_riscv_dram_window.sv
// Directed bench for riscv_dram_window: 64 KiB window relocated to 0x8000_0000, 8 outstanding.
module tb_riscv_dram_window;
  import riscv_axi_pkg::*;

  localparam int          IDW  = 5;
  localparam int          AW   = 32;
  localparam int          DW   = 64;
  localparam int          DB   = 16;
  localparam int          MAXO = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_dram_window_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
  riscv_dram_window_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
  logic          err_valid, err_is_write, err_clear;
  logic [AW-1:0] err_addr;
`endif

  riscv_dram_window #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DRAM_BASE(BASE), .DRAM_BITS(DB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_aclk     (clk),
    .axi_areset   (rst),
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_is_write (err_is_write),
    .err_clear    (err_clear),
`endif
    .s_axi        (s_if),
    .m_axi        (m_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
    s_if.awvalid = 0; s_if.awlock = 0; s_if.awcache = '0; s_if.awprot = '0;
    s_if.awqos = '0; s_if.awregion = '0;
    s_if.wdata = '0; s_if.wstrb = '1; s_if.wlast = 0; s_if.wvalid = 0; s_if.bready = 0;
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
    s_if.arvalid = 0; s_if.arlock = 0; s_if.arcache = '0; s_if.arprot = '0;
    s_if.arqos = '0; s_if.arregion = '0; s_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;
    m_if.rvalid = 0;
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    err_clear = 0;
`endif
  endtask

  task automatic set_ar(input int id, input logic [31:0] addr, input int len);
    s_if.arid = IDW'(id); s_if.araddr = addr; s_if.arlen = 8'(len);
    s_if.arsize = 3'd3; s_if.arburst = BURST_INCR; s_if.arvalid = 1;
  endtask

  task automatic set_aw(input int id, input logic [31:0] addr, input int len);
    s_if.awid = IDW'(id); s_if.awaddr = addr; s_if.awlen = 8'(len);
    s_if.awsize = 3'd3; s_if.awburst = BURST_INCR; s_if.awvalid = 1;
  endtask

  task automatic m_rbeat(input int id, input logic [63:0] data, input logic last);
    m_if.rvalid = 1; m_if.rid = IDW'(id); m_if.rdata = data; m_if.rresp = RESP_OKAY;
    m_if.rlast = last;
  endtask

  initial begin
    rst = 1;
    idle_all();
    set_ar(1, 32'h100, 0);
    m_if.arready = 1;
    tick(); tick(); #1;
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_s_arready", s_if.arready, 0);
    chk("rst_rd_cnt", dut.rd_cnt_q, 0);
    chk("rst_wr_state", dut.u_err.wr_state_q, W_IDLE);
    rst = 0;
    idle_all();
    tick();

    // 1: in-window read passes through relocated
    set_ar(3, 32'h100, 3);
    m_if.arready = 1; #1;
    chk("t1_m_arvalid", m_if.arvalid, 1);
    chk("t1_m_araddr", m_if.araddr, 32'h8000_0100);
    chk("t1_m_arlen", m_if.arlen, 3);
    chk("t1_m_arcache", m_if.arcache, 4'b0011);
    chk("t1_s_arready", s_if.arready, 1);
    tick();
    s_if.arvalid = 0; m_if.arready = 0; #1;
    chk("t1_rd_cnt1", dut.rd_cnt_q, 1);
    s_if.rready = 1;
    for (int i = 0; i < 4; i++) begin
      m_rbeat(3, 64'hA5A5_0000_0000_0000 + 64'(i), i == 3); #1;
      chk("t1_s_rdata", s_if.rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
      chk("t1_s_rlast", s_if.rlast, i == 3);
      tick();
    end
    m_if.rvalid = 0; #1;
    chk("t1_rd_cnt0", dut.rd_cnt_q, 0);

    // 2: out-of-window write drained locally, DECERR with latched ID
    set_aw(7, 32'h0001_0000, 1);
    m_if.awready = 1; #1;
    chk("t2_m_awvalid", m_if.awvalid, 0);
    chk("t2_s_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      s_if.wvalid = 1; s_if.wlast = (i == 1); s_if.wdata = 64'(i); #1;
      chk("t2_s_wready", s_if.wready, 1);
      chk("t2_m_wvalid", m_if.wvalid, 0);
      tick();
    end
    s_if.wvalid = 0; s_if.wlast = 0; s_if.bready = 0; #1;
    chk("t2_bvalid", s_if.bvalid, 1);
    chk("t2_bresp", s_if.bresp, 2'b11);
    chk("t2_bid", s_if.bid, 7);
    tick(); #1;
    chk("t2_bvalid_hold", s_if.bvalid, 1);
    s_if.bready = 1;
    tick(); #1;
    chk("t2_bvalid_done", s_if.bvalid, 0);
    s_if.bready = 0;
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    chk("t2_err_valid", err_valid, 1);
    chk("t2_err_addr", err_addr, 32'h0001_0000);
    chk("t2_err_is_write", err_is_write, 1);
`endif

    // 3: burst ending exactly at the window top is forwarded; one crossing it is not
    set_ar(1, 32'h0000_FFF0, 1);
    m_if.arready = 1; s_if.rready = 1; #1;
    chk("t3_edge_arvalid", m_if.arvalid, 1);
    chk("t3_edge_araddr", m_if.araddr, 32'h8000_FFF0);
    tick();
    s_if.arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      m_rbeat(1, 64'(i), i == 1);
      tick();
    end
    m_if.rvalid = 0; m_if.rlast = 0;
    set_ar(2, 32'h0000_FFF8, 1); #1;
    chk("t3_strad_arvalid", m_if.arvalid, 0);
    chk("t3_strad_arready", s_if.arready, 1);
    tick();
    s_if.arvalid = 0; s_if.rready = 0;
    tick(); #1;
    chk("t3_stall_rlast", s_if.rlast, 0);
    s_if.rready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_rvalid", s_if.rvalid, 1);
      chk("t3_rresp", s_if.rresp, 2'b11);
      chk("t3_rdata", s_if.rdata, 0);
      chk("t3_rid", s_if.rid, 2);
      chk("t3_rlast", s_if.rlast, i == 1);
      tick();
    end
    #1;
    chk("t3_rvalid_done", s_if.rvalid, 0);
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    chk("t3_err_addr_first", err_addr, 32'h0001_0000);
`endif

    // 4: ninth in-window AR stalls until one burst completes
    m_if.arready = 1;
    for (int i = 0; i < 8; i++) begin
      set_ar(i, 32'(i * 'h40), 0); #1;
      chk("t4_arready", s_if.arready, 1);
      tick();
    end
    set_ar(8, 32'h200, 0); #1;
    chk("t4_9th_arready", s_if.arready, 0);
    chk("t4_9th_arvalid", m_if.arvalid, 0);
    chk("t4_rd_cnt8", dut.rd_cnt_q, 8);
    tick();
    m_rbeat(0, 64'h0, 1); #1;
    chk("t4_same_cyc_arready", s_if.arready, 0);
    tick();
    m_if.rvalid = 0; #1;
    chk("t4_resume_arready", s_if.arready, 1);
    chk("t4_resume_arvalid", m_if.arvalid, 1);
    tick();
    s_if.arvalid = 0; #1;
    chk("t4_rd_cnt_refill", dut.rd_cnt_q, 8);
    for (int i = 1; i <= 8; i++) begin
      m_rbeat(i, 64'h0, 1);
      tick();
    end
    m_if.rvalid = 0; #1;
    chk("t4_rd_cnt_drained", dut.rd_cnt_q, 0);

    // 5: error AR waits for rd_cnt to reach 0; same-cycle inc/dec holds counts
    set_ar(1, 32'h200, 0);
    tick();
    set_ar(4, 32'h240, 0);
    m_rbeat(1, 64'h55, 1); #1;
    chk("t5_rvalid", s_if.rvalid, 1);
    chk("t5_rid", s_if.rid, 1);
    tick();
    m_if.rvalid = 0; #1;
    chk("t5_rd_cnt_incdec", dut.rd_cnt_q, 1);
    set_ar(5, 32'h280, 0);
    tick();
    set_ar(9, 32'h0002_0000, 0); #1;
    chk("t5_err_wait_ready", s_if.arready, 0);
    chk("t5_err_m_arvalid", m_if.arvalid, 0);
    chk("t5_rd_cnt2", dut.rd_cnt_q, 2);
    tick();
    m_rbeat(4, 64'h0, 1); #1;
    chk("t5_wait_cnt2", s_if.arready, 0);
    tick();
    m_rbeat(5, 64'h0, 1); #1;
    chk("t5_wait_cnt1", s_if.arready, 0);
    tick();
    m_if.rvalid = 0; #1;
    chk("t5_err_accept", s_if.arready, 1);
    tick();
    s_if.arvalid = 0; #1;
    chk("t5_err_rvalid", s_if.rvalid, 1);
    chk("t5_err_rid", s_if.rid, 9);
    chk("t5_err_rresp", s_if.rresp, 2'b11);
    chk("t5_err_rlast", s_if.rlast, 1);
    tick(); #1;
    chk("t5_err_done", s_if.rvalid, 0);
    m_if.arready = 0;

    m_if.awready = 1; m_if.wready = 1; s_if.bready = 1;
    set_aw(1, 32'h300, 0); #1;
    chk("t5_m_awvalid", m_if.awvalid, 1);
    chk("t5_m_awaddr", m_if.awaddr, 32'h8000_0300);
    tick();
    s_if.awvalid = 0; s_if.wvalid = 1; s_if.wlast = 1; #1;
    chk("t5_m_wvalid", m_if.wvalid, 1);
    tick();
    s_if.wvalid = 0;
    set_aw(2, 32'h340, 0);
    m_if.bvalid = 1; m_if.bid = 5'd1; m_if.bresp = RESP_OKAY; #1;
    chk("t5_s_bvalid", s_if.bvalid, 1);
    chk("t5_s_bid", s_if.bid, 1);
    tick();
    m_if.bvalid = 0; s_if.awvalid = 0; #1;
    chk("t5_wr_cnt_incdec", dut.wr_cnt_q, 1);
    s_if.wvalid = 1;
    tick();
    s_if.wvalid = 0; m_if.bvalid = 1; m_if.bid = 5'd2;
    tick();
    m_if.bvalid = 0; #1;
    chk("t5_wr_cnt0", dut.wr_cnt_q, 0);
    chk("t5_w_owed0", dut.w_owed_q, 0);
    idle_all();

    // 6: reset in the middle of W_DRAIN
    set_aw(6, 32'h0003_0000, 3);
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    err_clear = 1;
`endif
    #1;
    chk("t6_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 0;
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    err_clear = 0; #1;
    chk("t6_clear_wins", err_valid, 0);
`endif
    s_if.wvalid = 1; s_if.wlast = 0;
    tick(); #1;
    chk("t6_in_drain", dut.u_err.wr_state_q, W_DRAIN);
    rst = 1; #1;
    chk("t6_rst_wready", s_if.wready, 0);
    chk("t6_rst_bvalid", s_if.bvalid, 0);
    tick();
    rst = 0;
    idle_all(); #1;
    chk("t6_wr_state", dut.u_err.wr_state_q, W_IDLE);
    chk("t6_rd_state", dut.u_err.rd_state_q, R_IDLE);
    chk("t6_wr_cnt", dut.wr_cnt_q, 0);
    chk("t6_s_bvalid", s_if.bvalid, 0);

    // post-reset error read still answered with DECERR
    set_ar(3, 32'h0004_0000, 0);
    s_if.rready = 1; #1;
    chk("t6_err_arready", s_if.arready, 1);
    tick();
    s_if.arvalid = 0; #1;
    chk("t6_err_rresp", s_if.rresp, 2'b11);
    chk("t6_err_rid", s_if.rid, 3);
`ifdef RISCV_DRAM_WINDOW_ERRLOG_EN
    chk("t6_log_valid", err_valid, 1);
    chk("t6_log_addr", err_addr, 32'h0004_0000);
    chk("t6_log_is_write", err_is_write, 0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
